// File: rtl/u_imem_arb_pkg.sv
// Shared types and constants for the instruction-SRAM arbiter.
//   imem_arb_st_e : arbiter state (fetch / loader burst / forced IFU slot)
//   imem_own_e    : which requester owns the SRAM in a given cycle
//   IMEM_AW/IMEM_DW : default SRAM address / data widths
//   IMEM_BURST_W  : width of the loader burst counter
package u_imem_arb_pkg;

    localparam int IMEM_AW      = 16;
    localparam int IMEM_DW      = 32;
    localparam int IMEM_BURST_W = 8;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_LOAD  = 2'd1,
        S_YIELD = 2'd2
    } imem_arb_st_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LD  = 1'b1
    } imem_own_e;

endpackage

// File: rtl/u_imem_arb_sat_cnt.sv
// Saturating up-counter used for the arbiter performance counters.
// Only compiled when IMEM_ARB_PERF_EN is defined.
// Ports:
//   clk : clock, rising edge
//   clr : synchronous clear, active-high (dominates inc)
//   inc : count this cycle
//   cnt : current count, holds at all-ones
`ifdef IMEM_ARB_PERF_EN
module u_sat_cnt #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule
`endif

// File: rtl/u_imem_arb.sv
// Instruction-SRAM arbiter between the IFU fetch port and a loader/debug port.
// The loader wins whenever it requests, except in a forced one-cycle IFU slot
// after MAX_BURST consecutive loader grants (disabled in boot/halt mode).
// Read data returns to whichever requester owned the cycle the read issued.
// Optional feature macro: IMEM_ARB_PERF_EN adds perf_stall / perf_ldgnt
// saturating 32-bit counters.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   ifu_a, ifu_e                 : IFU fetch address / enable
//   ifu_stall, ifu_rvld, ifu_rdat: IFU stall, fetch data valid, fetch data
//   ld_req, ld_we, ld_adr, ld_wdat, ld_halt : loader request side
//   ld_gnt, ld_rvld, ld_rdat     : loader grant (comb), read valid, read data
//   mem_e, mem_we, mem_a, mem_wdat, mem_rdat : SRAM macro interface
//   perf_stall, perf_ldgnt       : performance counters (macro only)
module u_imem_arb
    import u_imem_arb_pkg::*;
#(
    parameter int AW        = IMEM_AW,
    parameter int DW        = IMEM_DW,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ifu_a,
    input  logic          ifu_e,
    output logic          ifu_stall,
    output logic          ifu_rvld,
    output logic [DW-1:0] ifu_rdat,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adr,
    input  logic [DW-1:0] ld_wdat,
    input  logic          ld_halt,
    output logic          ld_gnt,
    output logic          ld_rvld,
    output logic [DW-1:0] ld_rdat,
    output logic          mem_e,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wdat,
    input  logic [DW-1:0] mem_rdat
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [31:0]   perf_stall,
    output logic [31:0]   perf_ldgnt
`endif
);

    localparam logic [IMEM_BURST_W-1:0] LP_MAX_BURST = IMEM_BURST_W'(MAX_BURST);

    imem_arb_st_e            r_state, w_state_next;
    logic [IMEM_BURST_W-1:0] r_burst_cnt, w_burst_cnt_next, w_cnt_inc;
    imem_own_e               w_own, r_owner;
    logic                    r_rd, r_we;

    // Ownership and SRAM request muxing
    always_comb begin
        w_own = (ld_req && (r_state != S_YIELD)) ? OWN_LD : OWN_IFU;
    end

    assign ld_gnt    = (w_own == OWN_LD);
    assign ifu_stall = ld_gnt || ld_halt;
    assign mem_e     = ld_gnt || (ifu_e && !ld_halt);
    assign mem_we    = ld_gnt && ld_we;
    assign mem_a     = ld_gnt ? ld_adr : ifu_a;
    assign mem_wdat  = mem_we ? ld_wdat : '0;

    // Count of the grant being issued this cycle. Saturates so that a long
    // halt-mode burst can never wrap back below the limit.
    always_comb begin
        w_cnt_inc = 8'd1;
        if (r_state == S_LOAD) begin
            w_cnt_inc = (r_burst_cnt == 8'hFF) ? 8'hFF : (r_burst_cnt + 8'd1);
        end
    end

    // Next state. The limit check uses >= so a halt release in the middle of
    // a long burst still yields at the next grant.
    always_comb begin
        w_state_next     = r_state;
        w_burst_cnt_next = r_burst_cnt;
        unique case (r_state)
            S_FETCH, S_LOAD: begin
                if (ld_gnt) begin
                    w_burst_cnt_next = w_cnt_inc;
                    w_state_next     = (!ld_halt && (w_cnt_inc >= LP_MAX_BURST)) ? S_YIELD : S_LOAD;
                end else begin
                    w_burst_cnt_next = '0;
                    w_state_next     = S_FETCH;
                end
            end
            S_YIELD: begin
                w_burst_cnt_next = '0;
                w_state_next     = S_FETCH;
            end
            default: begin
                w_burst_cnt_next = '0;
                w_state_next     = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_FETCH;
            r_burst_cnt <= '0;
            r_owner     <= OWN_IFU;
            r_rd        <= 1'b0;
            r_we        <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_burst_cnt <= w_burst_cnt_next;
            r_owner     <= w_own;
            r_rd        <= mem_e;
            r_we        <= mem_we;
        end
    end

    // Read return: routed by the owner of the issuing cycle
    assign ifu_rvld = r_rd && (r_owner == OWN_IFU);
    assign ld_rvld  = r_rd && (r_owner == OWN_LD) && !r_we;
    assign ifu_rdat = ifu_rvld ? mem_rdat : '0;
    assign ld_rdat  = ld_rvld  ? mem_rdat : '0;

`ifdef IMEM_ARB_PERF_EN
    // Index 0: IFU wanted to fetch but lost its slot; index 1: loader grants
    logic [1:0]  w_perf_inc;
    logic [31:0] w_perf_cnt [2];

    assign w_perf_inc[0] = ifu_stall && ifu_e;
    assign w_perf_inc[1] = ld_gnt;

    for (genvar gi = 0; gi < 2; gi++) begin : g_perf
        u_sat_cnt #(
            .WIDTH (32)
        ) u_cnt (
            .clk (clk),
            .clr (rst),
            .inc (w_perf_inc[gi]),
            .cnt (w_perf_cnt[gi])
        );
    end

    assign perf_stall = w_perf_cnt[0];
    assign perf_ldgnt = w_perf_cnt[1];
`endif

endmodule
